// File: rtl/remote_volume_encoder.sv
// Volume-step phase encoder: queues +1/-1 requests in a saturating signed counter
// and emits one 2-bit phase transition per step, each held for DWELL clocks.
module remote_volume_encoder #(
   parameter int DWELL  = 1100000,
   parameter int PEND_W = 4
) (
   input  logic       Clk,
   input  logic       nReset,
   input  logic       Up,
   input  logic       Down,
   output logic [1:0] Phase,
   output logic       Busy,
   output logic       Dropped
);

   localparam int CNT_W = $clog2(DWELL);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
   localparam logic signed [PEND_W:0] ONE      = (PEND_W+1)'(1);
   localparam logic signed [PEND_W:0] NEG_ONE  = -ONE;
   localparam logic signed [PEND_W:0] PEND_MAX = (PEND_W+1)'((2 ** (PEND_W - 1)) - 1);
   localparam logic signed [PEND_W:0] PEND_MIN = -PEND_MAX;

   typedef enum logic {
      ST_IDLE,
      ST_DWELL
   } state_t;

   state_t                    state_reg, state_next;
   logic        [CNT_W-1:0]   count_reg, count_next;
   logic signed [PEND_W-1:0]  pending_reg, pending_next;
   logic        [1:0]         phase_reg, phase_next;
   logic                      busy_reg, busy_next;
   logic                      dropped_reg, dropped_next;

   logic                      issue;
   logic signed [PEND_W:0]    req_s, step_s, pend_ext, sum_s, pend_wide;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_reg   <= ST_IDLE;
         count_reg   <= '0;
         pending_reg <= '0;
         phase_reg   <= 2'b00;
         busy_reg    <= 1'b0;
         dropped_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         pending_reg <= pending_next;
         phase_reg   <= phase_next;
         busy_reg    <= busy_next;
         dropped_reg <= dropped_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      phase_next   = phase_reg;
      issue        = 1'b0;
      step_s       = '0;
      req_s        = '0;
      dropped_next = 1'b0;

      if (Up && !Down) begin
         req_s = ONE;
      end else if (Down && !Up) begin
         req_s = NEG_ONE;
      end

      // Expiring dwell with work queued issues immediately, so same-direction
      // steps are spaced exactly DWELL cycles with no idle gap.
      case (state_reg)
         ST_IDLE: begin
            if (pending_reg != '0) begin
               issue = 1'b1;
            end
         end
         ST_DWELL: begin
            if (count_reg == '0) begin
               if (pending_reg != '0) begin
                  issue = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               count_next = count_reg - CNT_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (issue) begin
         state_next = ST_DWELL;
         count_next = CNT_LOAD;
         if (!pending_reg[PEND_W-1]) begin
            phase_next = phase_reg + 2'd1;
            step_s     = ONE;
         end else begin
            phase_next = phase_reg - 2'd1;
            step_s     = NEG_ONE;
         end
      end

      // Saturation is judged on the pre-step count, one bit wider to avoid wrap.
      pend_ext = {pending_reg[PEND_W-1], pending_reg};
      sum_s    = pend_ext + req_s;
      if ((sum_s > PEND_MAX) || (sum_s < PEND_MIN)) begin
         pend_wide    = pend_ext - step_s;
         dropped_next = 1'b1;
      end else begin
         pend_wide    = sum_s - step_s;
      end
      pending_next = pend_wide[PEND_W-1:0];

      busy_next = (state_next == ST_DWELL) || (pending_next != '0);
   end

   assign Phase   = phase_reg;
   assign Busy    = busy_reg;
   assign Dropped = dropped_reg;

endmodule
